cla_share_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined 32-bit carry-lookahead adder among NREQ requesters. It accepts at most one operand set per cycle with a valid/ready handshake and drives the adder inputs from registers. A tag pipeline tracks each operation, and the block routes each sum/carry back to the requester that issued it. It sits between the requester blocks (multiplier/accumulator stages) and the shared adder instance.

---
 rtl/cla_share_arbiter_if.sv | 31 +++
 rtl/cla_share_arbiter.sv | 154 +++++++++++++++
 tb/tb_cla_share_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// cla_share_arbiter_if - requester-side handshake and result bus
// Rev 1.0
// ============================================================================
interface cla_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_cin,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/cla_share_arbiter.sv
`default_nettype none
// ============================================================================
// cla_share_arbiter - round-robin sharing of one pipelined adder among NREQ
// requesters, with a tag pipeline that routes each result back to its owner.
// Rev 1.0
// ============================================================================
module cla_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_share_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 busy,
    output logic [CNTW-1:0]      issue_cnt
);

    logic [IDW-1:0]            ptr_q, ptr_d;
    logic [NREQ-1:0]           hi_req;
    logic [NREQ-1:0]           grant_oh;
    logic                      grant_any;
    logic [IDW-1:0]            grant_id;

    logic [WIDTH-1:0]          sel_a, sel_b;
    logic                      sel_cin;

    logic [WIDTH-1:0]          add_a_q, add_a_d;
    logic [WIDTH-1:0]          add_b_q, add_b_d;
    logic                      add_cin_q, add_cin_d;

    logic                      issue_v_q, issue_v_d;
    logic [IDW-1:0]            issue_id_q, issue_id_d;
    logic [LAT-1:0]            tag_v_q, tag_v_d;
    logic [LAT-1:0][IDW-1:0]   tag_id_q, tag_id_d;

    logic [CNTW-1:0]           cnt_q, cnt_d;

    // Requesters at or above ptr take precedence; otherwise wrap to the lowest valid one.
    always_comb begin
        hi_req    = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_req[i] = bus.req_valid[i] && (IDW'(i) >= ptr_q);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_cin  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = grant_any && (grant_id == IDW'(i));
            if (grant_oh[i]) begin
                sel_a   = bus.req_a[i*WIDTH +: WIDTH];
                sel_b   = bus.req_b[i*WIDTH +: WIDTH];
                sel_cin = bus.req_cin[i];
            end
        end
    end

    assign bus.req_ready = grant_oh;

    always_comb begin
        ptr_d      = ptr_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_cin_d  = add_cin_q;
        issue_v_d  = grant_any;
        issue_id_d = grant_id;
        cnt_d      = cnt_q;
        if (grant_any) begin
            ptr_d     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            add_a_d   = sel_a;
            add_b_d   = sel_b;
            add_cin_d = sel_cin;
            cnt_d     = cnt_q + CNTW'(1);
        end
    end

    // Tag stage LAT-1 lines up with the adder output for the same operation.
    always_comb begin
        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = issue_v_q;
        tag_id_d[0] = issue_id_q;
        for (int s = 1; s < LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            issue_v_q  <= 1'b0;
            issue_id_q <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_cin_q  <= add_cin_d;
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.rsp_valid[i] = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == IDW'(i));
        end
        bus.rsp_sum  = tag_v_q[LAT-1] ? add_sum           : '0;
        bus.rsp_cout = tag_v_q[LAT-1] ? add_cout          : 1'b0;
        bus.rsp_id   = tag_v_q[LAT-1] ? tag_id_q[LAT-1]   : '0;
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign busy      = issue_v_q || (|tag_v_q);
    assign issue_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_cla_share_arbiter - scoreboard bench with a behavioural pipelined adder
// Rev 1.0
// ============================================================================
module tb_cla_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 2;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cla_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout, busy;
    logic [CNTW-1:0]  issue_cnt;

    cla_share_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    // Adder model without reset: old sums keep flowing after a reset.
    logic [LAT-1:0][WIDTH:0] apipe;
    always @(posedge clk) begin
        apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
    end
    assign add_sum  = apipe[LAT-1][WIDTH-1:0];
    assign add_cout = apipe[LAT-1][WIDTH];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               due;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];
    logic [NREQ-1:0]  opc;

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
            opc[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v);
        @(negedge clk);
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = opa[i];
            bus.req_b[i*WIDTH +: WIDTH] = opb[i];
            bus.req_cin[i]              = opc[i];
        end
        #1;
    endtask

    task automatic push_exp(input int g);
        exp_t e;
        logic [WIDTH:0] s;
        s      = {1'b0, opa[g]} + {1'b0, opb[g]} + {{WIDTH{1'b0}}, opc[g]};
        e.id   = g;
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        e.due  = cyc + 1 + LAT;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rsp_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                total++; bad++;
                $display("FAIL rsp_missing: id=%0d due cycle %0d passed (now %0d) without rsp_valid", e.id, e.due, cyc);
            end
            total++;
            if (bus.rsp_valid === '0) begin
                if (bus.rsp_sum !== '0 || bus.rsp_cout !== 1'b0 || bus.rsp_id !== '0) begin
                    bad++;
                    $display("FAIL rsp_idle: sum=%h cout=%b id=%0d required all zero", bus.rsp_sum, bus.rsp_cout, bus.rsp_id);
                end
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: rsp_valid=%b required 0 (cycle %0d)", bus.rsp_valid, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_valid !== NREQ'(1 << e.id) || bus.rsp_id !== IDW'(e.id) ||
                    bus.rsp_sum !== e.sum || bus.rsp_cout !== e.cout || cyc != e.due) begin
                    bad++;
                    $display("FAIL rsp_data: valid=%b id=%0d sum=%h cout=%b cyc=%0d required valid=%b id=%0d sum=%h cout=%b cyc=%0d",
                             bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, cyc,
                             NREQ'(1 << e.id), e.id, e.sum, e.cout, e.due);
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_cin = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || issue_cnt !== '0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b cnt=%0d a=%h b=%h cin=%b required all zero", busy, issue_cnt, add_a, add_b, add_cin);
        end
        total++;
        if (bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
            bad++;
            $display("FAIL reset_hs: rsp_valid=%b req_ready=%b required 0/0", bus.rsp_valid, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        rand_ops();
        opa[0] = 32'd100; opb[0] = 32'd200; opc[0] = 1'b0;
        drive(4'b0001);
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant: req_ready=%b required 0001", bus.req_ready);
        end
        push_exp(0);
        for (int k = 1; k <= 4; k++) begin
            drive(4'b0000);
            total++;
            if (busy !== (k <= 3)) begin
                bad++; $display("FAIL single_busy: k=%0d busy=%b required %b", k, busy, (k <= 3));
            end
            if (k == 1) begin
                total++;
                if (add_a !== 32'd100 || add_b !== 32'd200 || add_cin !== 1'b0 || issue_cnt !== 4'd1) begin
                    bad++;
                    $display("FAIL single_issue: a=%0d b=%0d cin=%b cnt=%0d required 100 200 0 1", add_a, add_b, add_cin, issue_cnt);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            drive(4'b1111);
            total++;
            if (bus.req_ready !== NREQ'(1 << (k % NREQ))) begin
                bad++; $display("FAIL rr_grant: k=%0d req_ready=%b required %b", k, bus.req_ready, NREQ'(1 << (k % NREQ)));
            end
            push_exp(k % NREQ);
        end
        drive(4'b0000);
        total++;
        if (issue_cnt !== 4'd8) begin
            bad++; $display("FAIL rr_count: issue_cnt=%0d required 8", issue_cnt);
        end
        repeat (LAT + 1) drive(4'b0000);
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] vpat [4];
        logic [NREQ-1:0] gexp [4];
        int              gid  [4];
        vpat = '{4'b0100, 4'b1010, 4'b1010, 4'b1001};
        gexp = '{4'b0100, 4'b1000, 4'b0010, 4'b1000};
        gid  = '{2, 3, 1, 3};
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            drive(vpat[k]);
            total++;
            if (bus.req_ready !== gexp[k]) begin
                bad++; $display("FAIL fair_grant: step=%0d req_ready=%b required %b", k, bus.req_ready, gexp[k]);
            end
            push_exp(gid[k]);
        end
        repeat (LAT + 1) drive(4'b0000);
    endtask

    task automatic test_overflow();
        rand_ops();
        opa[1] = 32'hFFFF_FFFF; opb[1] = 32'd1; opc[1] = 1'b0;
        drive(4'b0010);
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL ovf_grant: req_ready=%b required 0010", bus.req_ready);
        end
        push_exp(1);
        opa[1] = 32'd40; opb[1] = 32'd50; opc[1] = 1'b1;
        drive(4'b0010);
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL ovf_grant2: req_ready=%b required 0010", bus.req_ready);
        end
        push_exp(1);
        drive(4'b0000);
        drive(4'b0000);
        total++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_sum !== 32'd0 || bus.rsp_cout !== 1'b1 || bus.rsp_id !== 2'd1) begin
            bad++;
            $display("FAIL ovf_result: valid=%b sum=%h cout=%b id=%0d required 0010 0 1 1", bus.rsp_valid, bus.rsp_sum, bus.rsp_cout, bus.rsp_id);
        end
        drive(4'b0000);
        total++;
        if (bus.rsp_sum !== 32'd91 || bus.rsp_cout !== 1'b0) begin
            bad++; $display("FAIL ovf_cin: sum=%0d cout=%b required 91 0", bus.rsp_sum, bus.rsp_cout);
        end
        repeat (LAT) drive(4'b0000);
    endtask

    task automatic test_reset_midflight();
        rand_ops();
        drive(4'b0001);
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_grant0: req_ready=%b required 0001", bus.req_ready);
        end
        drive(4'b0010);
        total++;
        if (bus.req_ready !== 4'b0010) begin
            bad++; $display("FAIL mid_grant1: req_ready=%b required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        sb.delete();
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || issue_cnt !== '0 || bus.rsp_valid !== '0) begin
            bad++; $display("FAIL mid_reset: busy=%b cnt=%0d rsp_valid=%b required 0 0 0", busy, issue_cnt, bus.rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            drive(4'b0000);
            total++;
            if (busy !== 1'b0 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
                bad++; $display("FAIL mid_stale: k=%0d busy=%b rsp_valid=%b req_ready=%b required 0", k, busy, bus.rsp_valid, bus.req_ready);
            end
        end
        rand_ops();
        drive(4'b1111);
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++; $display("FAIL mid_next: req_ready=%b required 0001", bus.req_ready);
        end
        push_exp(0);
        repeat (LAT + 1) drive(4'b0000);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            rand_ops();
            drive(4'b1111);
            total++;
            if (issue_cnt !== CNTW'(k) || bus.req_ready !== NREQ'(1 << (k % NREQ))) begin
                bad++;
                $display("FAIL wrap_step: k=%0d cnt=%0d ready=%b required %0d %b", k, issue_cnt, bus.req_ready, CNTW'(k), NREQ'(1 << (k % NREQ)));
            end
            push_exp(k % NREQ);
        end
        drive(4'b0000);
        total++;
        if (issue_cnt !== 4'd1) begin
            bad++; $display("FAIL wrap_count: issue_cnt=%0d required 1", issue_cnt);
        end
        repeat (LAT + 3) drive(4'b0000);
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL drain: %0d results outstanding required 0", sb.size());
        end
    endtask

    initial begin
        fork
            rsp_monitor();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_overflow();
        test_reset_midflight();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
